// File: rtl/mpy_sequencer.sv
// Operand FIFO + one-job-at-a-time driver for an unsigned shift-add multiplier, with sign
// handling. Acceptance to o_valid = 3 + busy cycles; o_ready drops only when the FIFO is full.
module mpy_sequencer #(
   parameter int IW     = 32,
   parameter int LGFIFO = 2
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [IW-1:0]   i_a,
   input  logic [IW-1:0]   i_b,
   input  logic            i_signed,
   output logic            o_mpy_stb,
   output logic [IW-1:0]   o_mpy_a,
   output logic [IW-1:0]   o_mpy_b,
   input  logic            i_mpy_busy,
   input  logic [2*IW-1:0] i_mpy_result,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [2*IW-1:0] o_result
);

   localparam int EW    = 2*IW + 1;
   localparam int DEPTH = 2**LGFIFO;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   // ---------------- operand FIFO: {|a|, |b|, neg} ----------------
   logic [EW-1:0]   mem_q [DEPTH];
   logic [LGFIFO:0] wr_q, wr_d, rd_q, rd_d;
   logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [EW-1:0]   push_dat, head_dat;
   logic [IW-1:0]   mag_a, mag_b;
   logic            push_neg;

   // Negation is modulo 2^IW, so the most negative value maps to itself.
   always_comb begin
      mag_a    = (i_signed && i_a[IW-1]) ? -i_a : i_a;
      mag_b    = (i_signed && i_b[IW-1]) ? -i_b : i_b;
      push_neg = i_signed & (i_a[IW-1] ^ i_b[IW-1]);
      push_dat = {mag_a, mag_b, push_neg};
   end

   assign fifo_full  = (wr_q ^ rd_q) == {1'b1, {LGFIFO{1'b0}}};
   assign fifo_empty = (wr_q == rd_q);
   assign fifo_push  = i_valid && !fifo_full;
   assign o_ready    = !fifo_full;
   assign head_dat   = mem_q[rd_q[LGFIFO-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (fifo_push) wr_d = wr_q + 1'b1;
      if (fifo_pop)  rd_d = rd_q + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (fifo_push) mem_q[wr_q[LGFIFO-1:0]] <= push_dat;
   end

   // ---------------- job sequencer ----------------
   state_t          state_q, state_d;
   logic            stb_q, stb_d;
   logic [IW-1:0]   mpy_a_q, mpy_a_d, mpy_b_q, mpy_b_d;
   logic            neg_q, neg_d;
   logic            valid_q, valid_d;
   logic [2*IW-1:0] result_q, result_d;

   always_comb begin
      state_d  = state_q;
      stb_d    = stb_q;
      mpy_a_d  = mpy_a_q;
      mpy_b_d  = mpy_b_q;
      neg_d    = neg_q;
      valid_d  = valid_q;
      result_d = result_q;
      fifo_pop = 1'b0;
      case (state_q)
         // Waiting on busy also covers a multiplier still running a job from before a reset.
         S_IDLE: begin
            if (!fifo_empty && !i_mpy_busy) begin
               fifo_pop                   = 1'b1;
               {mpy_a_d, mpy_b_d, neg_d}  = head_dat;
               stb_d                      = 1'b1;
               state_d                    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            stb_d   = 1'b0;
            state_d = S_WAIT;
         end
         // The product is only present on the first non-busy cycle.
         S_WAIT: begin
            if (!i_mpy_busy) begin
               result_d = neg_q ? -i_mpy_result : i_mpy_result;
               valid_d  = 1'b1;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (i_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= S_IDLE;
         stb_q    <= 1'b0;
         mpy_a_q  <= '0;
         mpy_b_q  <= '0;
         neg_q    <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         stb_q    <= stb_d;
         mpy_a_q  <= mpy_a_d;
         mpy_b_q  <= mpy_b_d;
         neg_q    <= neg_d;
         valid_q  <= valid_d;
         result_q <= result_d;
      end
   end

   assign o_mpy_stb = stb_q;
   assign o_mpy_a   = mpy_a_q;
   assign o_mpy_b   = mpy_b_q;
   assign o_valid   = valid_q;
   assign o_result  = result_q;

endmodule

// File: tb/tb_mpy_sequencer.sv
// Bench for mpy_sequencer: unreset 32-cycle shift-add multiplier model plus a result scoreboard.
module tb_mpy_sequencer;
   localparam int IW = 32;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic          i_valid, o_ready, i_signed, i_ready;
   logic [IW-1:0] i_a, i_b;
   logic          o_mpy_stb;
   logic [IW-1:0] o_mpy_a, o_mpy_b;
   logic          o_valid;
   logic [63:0]   o_result;

   // Multiplier model: never reset, product present for exactly one cycle after busy falls.
   logic        mdl_busy = 1'b0;
   int          mdl_cnt  = 0;
   logic [63:0] mdl_prod = '0;
   logic [63:0] mdl_res  = '0;

   mpy_sequencer #(.IW(IW), .LGFIFO(2)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_a(i_a), .i_b(i_b), .i_signed(i_signed),
      .o_mpy_stb(o_mpy_stb), .o_mpy_a(o_mpy_a), .o_mpy_b(o_mpy_b),
      .i_mpy_busy(mdl_busy), .i_mpy_result(mdl_res),
      .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) begin
      mdl_res <= '0;
      if (mdl_busy) begin
         if (mdl_cnt == 0) begin
            mdl_busy <= 1'b0;
            mdl_res  <= mdl_prod;
         end else begin
            mdl_cnt <= mdl_cnt - 1;
         end
      end else if (o_mpy_stb) begin
         mdl_busy <= 1'b1;
         mdl_cnt  <= 31;
         mdl_prod <= {32'd0, o_mpy_a} * {32'd0, o_mpy_b};
      end
   end

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h, expected 0x%h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] exp_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
      logic signed [63:0] sa, sb;
      if (s) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         return sa * sb;
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
      return (s && x[31]) ? -x : x;
   endfunction

   logic [63:0] exp_q[$];
   logic [63:0] op_q[$];
   int          acc_cyc   = 0;
   int          vrise_cyc = 0;
   logic        vprev     = 1'b0;

   // Output monitor: operand check on each strobe, scoreboard pop on each consumed result.
   always @(negedge i_clk) begin
      logic [63:0] e;
      if (i_reset) begin
         vprev = 1'b0;
      end else begin
         if (o_mpy_stb) begin
            check("stb_while_busy", 64'(mdl_busy), 64'd0);
            if (op_q.size() == 0) check("unexpected_stb", 64'd1, 64'd0);
            else begin
               e = op_q.pop_front();
               check("mpy_a", 64'(o_mpy_a), 64'(e[63:32]));
               check("mpy_b", 64'(o_mpy_b), 64'(e[31:0]));
            end
         end
         if (o_valid && !vprev) vrise_cyc = cyc;
         vprev = o_valid;
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
            else begin
               e = exp_q.pop_front();
               check("result", o_result, e);
            end
         end
      end
   end

   // Called aligned to posedge+1; returns aligned to posedge+1.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
      int n;
      i_valid  = 1'b1;
      i_a      = a;
      i_b      = b;
      i_signed = s;
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_ready && n < 3000);
      if (!o_ready) begin
         i_valid = 1'b0;
         check("accept_timeout", 64'd0, 64'd1);
      end else begin
         exp_q.push_back(exp_prod(a, b, s));
         op_q.push_back({mag(a, s), mag(b, s)});
         acc_cyc = cyc + 1;
      end
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge i_clk);
         n++;
      end
      check(tag, 64'(exp_q.size()), 64'd0);
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},  64'(o_ready),   64'd1);
      check({tag, "_stb"},    64'(o_mpy_stb), 64'd0);
      check({tag, "_mpy_a"},  64'(o_mpy_a),   64'd0);
      check({tag, "_mpy_b"},  64'(o_mpy_b),   64'd0);
      check({tag, "_valid"},  64'(o_valid),   64'd0);
      check({tag, "_result"}, o_result,       64'd0);
   endtask

   logic [31:0] ta [6];
   logic [31:0] tb [6];
   logic        ts [6];

   initial begin
      int n;
      i_reset  = 1'b1;
      i_valid  = 1'b0;
      i_a      = '0;
      i_b      = '0;
      i_signed = 1'b0;
      i_ready  = 1'b1;
      ta = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_0000, 32'd100};
      tb = '{32'd6, 32'd2, 32'd1, 32'h9ABC_DEF0, 32'hFFFF_0000, 32'hFFFF_FF9C};
      ts = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

      repeat (3) @(posedge i_clk);
      #1;
      check_reset_outputs("rst0");
      i_reset = 1'b0;
      @(posedge i_clk);
      #1;

      // Basic unsigned job, including acceptance-to-valid latency.
      send(32'd3, 32'd5, 1'b0);
      wait_drain("drain_unsigned");
      check("latency", 64'(vrise_cyc - acc_cyc), 64'd35);

      // Signed and extreme operands.
      send(32'hFFFF_FFFD, 32'd5, 1'b1);
      wait_drain("drain_signed");
      send(32'h8000_0000, 32'h8000_0000, 1'b1);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      send(32'd0, 32'hFFFF_FFFF, 1'b1);
      wait_drain("drain_extremes");

      // Buffering with the result stream stalled.
      i_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 6; k++) send(ta[k], tb[k], ts[k]);
         end
         begin
            int m;
            m = 0;
            while (!o_valid && m < 200) begin
               @(negedge i_clk);
               m++;
            end
            check("buf_first_valid", 64'(o_valid), 64'd1);
            @(negedge i_clk);
            check("buf_full_stall", 64'(o_ready), 64'd0);
            repeat (10) begin
               @(negedge i_clk);
               check("buf_hold_result", o_result, exp_q[0]);
               check("buf_hold_valid", 64'(o_valid), 64'd1);
            end
            i_ready = 1'b1;
         end
      join
      wait_drain("drain_buffered");

      // Reset while the multiplier is mid-job, with more jobs queued behind it.
      send(32'd1000, 32'd1000, 1'b0);
      send(32'd2, 32'd3, 1'b0);
      send(32'd4, 32'd5, 1'b0);
      n = 0;
      while (!mdl_busy && n < 100) begin
         @(negedge i_clk);
         n++;
      end
      check("rst_job_started", 64'(mdl_busy), 64'd1);
      repeat (9) @(negedge i_clk);
      i_reset = 1'b1;
      exp_q.delete();
      op_q.delete();
      #1;
      check_reset_outputs("rst_wait");
      @(negedge i_clk);
      check_reset_outputs("rst_hold");
      i_reset = 1'b0;
      @(posedge i_clk);
      #1;
      send(32'hFFFF_FFF9, 32'd9, 1'b1);
      wait_drain("drain_after_reset");
      repeat (60) @(negedge i_clk);
      check("no_stale_jobs", 64'(o_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
